// File: rtl/serdes_gearbox_tx.sv
// serdes_gearbox_tx: multi-lane IN_WIDTH:OUT_WIDTH transmit gearbox.
// Accepts one IN_WIDTH-bit word per lane on a shared valid/ready handshake and
// emits OUT_WIDTH bits per lane every clock, LSB first. When the source stalls
// at an append slot, IDLE_WORD is inserted so the line never stops.
// Optional build macro SERDES_GEARBOX_TX_PRBS_EN adds input i_prbs, which
// replaces appended words with a PRBS7 (x^7+x^6+1) pattern on every lane.
module serdes_gearbox_tx #(
  parameter int                  IN_WIDTH  = 10,
  parameter int                  OUT_WIDTH = 4,
  parameter int                  LANES     = 3,
  parameter logic [IN_WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*IN_WIDTH-1:0]    i_data,
  input  logic                         i_valid,
`ifdef SERDES_GEARBOX_TX_PRBS_EN
  input  logic                         i_prbs,
`endif
  output logic                         o_ready,
  output logic [LANES*OUT_WIDTH-1:0]   o_data,
  output logic                         o_underflow
);

  // Fill counter must hold 0..IN_WIDTH-1 and be comparable against OUT_WIDTH,
  // which may equal IN_WIDTH.
  localparam int FW = $clog2(IN_WIDTH + 1);
  // Residual buffer per lane: at most IN_WIDTH-1 bits are ever left over.
  localparam int BW = IN_WIDTH - 1;
  // Concatenation of a full word above the largest residual.
  localparam int CW = 2 * IN_WIDTH - 1;

  logic [FW-1:0]                      fill;
  logic [FW-1:0]                      fill_nxt;
  logic [LANES*BW-1:0]                lane_buf;
  logic [LANES*BW-1:0]                lane_buf_nxt;
  logic [LANES*OUT_WIDTH-1:0]         data_nxt;
  logic                               underflow_nxt;
  logic                               append;
  logic [BW-1:0]                      keep_mask;
  logic [CW-1:0]                      lane_c;
  logic [LANES-1:0][IN_WIDTH-1:0]     src_word;

  // Room for a new word exactly when fewer than one output beat is buffered.
  assign o_ready = (fill < FW'(OUT_WIDTH));
  assign append  = o_ready;

  // Only the low `fill` buffer bits are live; the mask saturates to all-ones
  // when fill == BW because the shifted one falls off the top.
  assign keep_mask = (BW'(1) << fill) - BW'(1);

`ifdef SERDES_GEARBOX_TX_PRBS_EN
  logic [6:0]          prbs_q;
  logic [6:0]          prbs_nxt;
  logic [6:0]          prbs_s;
  logic [IN_WIDTH-1:0] prbs_word;
  logic                prbs_bit;

  // Run the PRBS7 generator IN_WIDTH steps ahead; commit only on an append.
  always_comb begin
    prbs_s    = prbs_q;
    prbs_word = '0;
    prbs_bit  = 1'b0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      prbs_bit     = prbs_s[6] ^ prbs_s[5];
      prbs_word[i] = prbs_bit;
      prbs_s       = {prbs_s[5:0], prbs_bit};
    end
    prbs_nxt = (append && i_prbs) ? prbs_s : prbs_q;
  end

  // Generator state; seeded all-ones so the sequence restarts after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prbs_q <= 7'h7F;
    end else begin
      prbs_q <= prbs_nxt;
    end
  end

  // Word source per lane: PRBS pattern, live data, or idle fill.
  always_comb begin
    src_word      = '0;
    underflow_nxt = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_prbs) begin
        src_word[k] = prbs_word;
      end else if (i_valid) begin
        src_word[k] = i_data[k*IN_WIDTH +: IN_WIDTH];
      end else begin
        src_word[k] = IDLE_WORD;
      end
    end
    underflow_nxt = append && !i_valid && !i_prbs;
  end
`else
  // Word source per lane: live data, or idle fill when the source stalls.
  always_comb begin
    src_word      = '0;
    underflow_nxt = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_valid) begin
        src_word[k] = i_data[k*IN_WIDTH +: IN_WIDTH];
      end else begin
        src_word[k] = IDLE_WORD;
      end
    end
    underflow_nxt = append && !i_valid;
  end
`endif

  // Per lane: stack the new word above the live residual, emit the low beat,
  // keep the remainder for later beats.
  always_comb begin
    lane_c       = '0;
    data_nxt     = '0;
    lane_buf_nxt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_c = CW'(lane_buf[k*BW +: BW] & keep_mask);
      if (append) begin
        lane_c = lane_c | (CW'(src_word[k]) << fill);
      end
      data_nxt[k*OUT_WIDTH +: OUT_WIDTH] = lane_c[OUT_WIDTH-1:0];
      lane_buf_nxt[k*BW +: BW]           = lane_c[OUT_WIDTH +: BW];
    end
  end

  // Fill bookkeeping shared by all lanes.
  always_comb begin
    fill_nxt = fill - FW'(OUT_WIDTH);
    if (append) begin
      fill_nxt = fill + FW'(IN_WIDTH - OUT_WIDTH);
    end
  end

  // State and registered outputs; reset discards any partial residual.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill        <= '0;
      lane_buf    <= '0;
      o_data      <= '0;
      o_underflow <= 1'b0;
    end else begin
      fill        <= fill_nxt;
      lane_buf    <= lane_buf_nxt;
      o_data      <= data_nxt;
      o_underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_serdes_gearbox_tx.sv
// Testbench for serdes_gearbox_tx: bit-queue reference model feeding a
// scoreboard, plus directed checks from fixed expected tables.
module tb_serdes_gearbox_tx;

  localparam int IN_W  = 10;
  localparam int OUT_W = 4;
  localparam int LANES = 3;
  localparam int DW    = LANES * IN_W;
  localparam int OW    = LANES * OUT_W;
  localparam logic [IN_W-1:0] IDLE = 10'b1101010100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [OW-1:0] o_data;
  logic          o_underflow;
`ifdef SERDES_GEARBOX_TX_PRBS_EN
  logic          i_prbs = 1'b0;
`endif

  serdes_gearbox_tx #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .LANES    (LANES),
    .IDLE_WORD(IDLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
`ifdef SERDES_GEARBOX_TX_PRBS_EN
    .i_prbs     (i_prbs),
`endif
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [OW-1:0] data;
    logic          uf;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  bit   lane_q[LANES][$];
`ifdef SERDES_GEARBOX_TX_PRBS_EN
  bit   prbs_hist[$];
`endif

  // Each lane is a FIFO of bits in transmit order; a word is appended when
  // less than one beat is queued, and one beat leaves every clock.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) lane_q[k].delete();
      exp_q.delete();
`ifdef SERDES_GEARBOX_TX_PRBS_EN
      prbs_hist.delete();
      for (int i = 0; i < 7; i++) prbs_hist.push_back(1'b1);
`endif
    end else begin
      exp_t            e;
      logic [IN_W-1:0] w;
      bit              use_prbs;
      e.data   = '0;
      e.uf     = 1'b0;
      e.rdy    = 1'b0;
      w        = '0;
      use_prbs = 1'b0;
`ifdef SERDES_GEARBOX_TX_PRBS_EN
      use_prbs = i_prbs;
`endif
      if (lane_q[0].size() < OUT_W) begin
        if (use_prbs) begin
`ifdef SERDES_GEARBOX_TX_PRBS_EN
          // o[n] = o[n-7] ^ o[n-6], history primed with seven ones
          for (int i = 0; i < IN_W; i++) begin
            w[i] = prbs_hist[$-6] ^ prbs_hist[$-5];
            prbs_hist.push_back(w[i]);
          end
          while (prbs_hist.size() > 16) void'(prbs_hist.pop_front());
`endif
        end else begin
          e.uf = !i_valid;
        end
        for (int k = 0; k < LANES; k++) begin
          if (!use_prbs) w = i_valid ? i_data[k*IN_W +: IN_W] : IDLE;
          for (int b = 0; b < IN_W; b++) lane_q[k].push_back(w[b]);
        end
      end
      for (int k = 0; k < LANES; k++)
        for (int b = 0; b < OUT_W; b++)
          e.data[k*OUT_W + b] = lane_q[k].pop_front();
      e.rdy = (lane_q[0].size() < OUT_W);
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_o_data", 64'(o_data), 64'(e.data));
        check("sb_o_underflow", 64'(o_underflow), 64'(e.uf));
        check("sb_o_ready", 64'(o_ready), 64'(e.rdy));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit hold = 1'b0;

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b0;
    hold    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_o_data", 64'(o_data), 64'(0));
    check("rst_o_underflow", 64'(o_underflow), 64'(0));
    check("rst_o_ready", 64'(o_ready), 64'(1));
  endtask

  // One cycle from a negedge: a pending stalled word is held stable.
  task automatic cycle(input bit v);
    if (!hold) begin
      i_valid = v;
      if (v) i_data = DW'($urandom());
    end
    hold = i_valid && !o_ready;
    @(negedge clk);
  endtask

  bit          ready_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0]  beat_tab[5]  = '{4'hF, 4'hF, 4'h3, 4'h0, 4'h0};
  logic [IN_W-1:0] w0;
  int          uf_cnt;

  initial begin
    // ready pattern with a continuously valid source
    do_reset();
    for (int c = 0; c < 15; c++) begin
      check("ready_pattern", 64'(o_ready), 64'(ready_pat[c % 5]));
      cycle(1'b1);
    end

    // 3FF then 000 on every lane
    do_reset();
    i_valid = 1'b1;
    i_data  = {LANES{10'h3FF}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("beat_table", 64'(o_data), 64'({LANES{beat_tab[i]}}));
      @(negedge clk);
      if (i == 1) i_data = '0;
    end

    // idle insertion from reset
    do_reset();
    i_valid = 1'b0;
    uf_cnt  = 0;
    @(posedge clk);
    #1;
    check("idle_first_beat", 64'(o_data[3:0]), 64'(4'b0100));
    check("idle_first_uf", 64'(o_underflow), 64'(1));
    if (o_underflow) uf_cnt++;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (o_underflow) uf_cnt++;
    end
    check("idle_uf_count", 64'(uf_cnt), 64'(8));

    // random traffic with valid gaps
    @(negedge clk);
    do_reset();
    for (int c = 0; c < 400; c++) cycle($urandom_range(0, 3) != 0);

    // reset mid-stream with six bits buffered
    do_reset();
    cycle(1'b1);
    reset = 1'b1;
    #1;
    check("midrst_o_data", 64'(o_data), 64'(0));
    check("midrst_o_underflow", 64'(o_underflow), 64'(0));
    check("midrst_o_ready", 64'(o_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    hold    = 1'b0;
    w0      = IN_W'($urandom());
    i_valid = 1'b1;
    i_data  = {LANES{w0}};
    @(posedge clk);
    #1;
    check("midrst_first_beat", 64'(o_data), 64'({LANES{w0[3:0]}}));
    @(negedge clk);
    for (int c = 0; c < 40; c++) cycle($urandom_range(0, 1) != 0);

`ifdef SERDES_GEARBOX_TX_PRBS_EN
    // PRBS7 capture (over 1270 bits per lane) with random i_valid ignored
    do_reset();
    i_prbs = 1'b1;
    for (int c = 0; c < 330; c++) begin
      i_valid = $urandom_range(0, 1) != 0;
      i_data  = DW'($urandom());
      @(negedge clk);
    end
    i_prbs  = 1'b0;
    i_valid = 1'b0;
    hold    = 1'b0;
    for (int c = 0; c < 20; c++) cycle(1'b1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
